// File: rtl/slow_clk_pkg.sv
// Shared definitions for the slow clock generator: FSM state encoding and
// the default phase-count width.
package slow_clk_pkg;

  localparam int DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/phase_ctr.sv
// Loadable down-counter that times one slow-clock phase. It counts down to
// zero, then holds there until it is reloaded.
module phase_ctr
  import slow_clk_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/slow_clk_gen.sv
// Programmable slow clock generator: independent high/low phase lengths,
// stretch at terminal count, and clean park-low when the run request drops.
module slow_clk_gen
  import slow_clk_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             en,
  input  logic [CNT_W-1:0] hi_cnt,
  input  logic [CNT_W-1:0] lo_cnt,
  input  logic             stretch,
  output logic             dout,
  output logic             rise,
  output logic             fall,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             dout_q, dout_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             ctr_load;
  logic [CNT_W-1:0] ctr_load_val;
  logic             ctr_zero;

  phase_ctr #(.CNT_W(CNT_W)) u_phase_ctr (
    .clk      (clk),
    .arst     (arst),
    .load     (ctr_load),
    .load_val (ctr_load_val),
    .zero     (ctr_zero)
  );

  // Phase lengths are captured only on entry; a phase ends at count zero
  // unless stretch holds it there.
  always_comb begin
    state_d      = state_q;
    ctr_load     = 1'b0;
    ctr_load_val = '0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d      = ST_HIGH;
          ctr_load     = 1'b1;
          ctr_load_val = hi_cnt;
        end
      end
      ST_HIGH: begin
        if (ctr_zero && !stretch) begin
          state_d      = ST_LOW;
          ctr_load     = 1'b1;
          ctr_load_val = lo_cnt;
        end
      end
      ST_LOW: begin
        if (ctr_zero && !stretch) begin
          if (en) begin
            state_d      = ST_HIGH;
            ctr_load     = 1'b1;
            ctr_load_val = hi_cnt;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes fire in the first cycle of the new level, aligned with dout.
    dout_d = (state_d == ST_HIGH);
    rise_d = (state_d == ST_HIGH) && (state_q != ST_HIGH);
    fall_d = (state_d == ST_LOW) && (state_q == ST_HIGH);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= ST_IDLE;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_slow_clk_gen.sv
// Self-checking bench for slow_clk_gen: phase-length reference model compared
// every cycle, plus directed scenarios pinned with hand-computed run lengths.
module tb_slow_clk_gen;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             arst;
  logic             en;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] lo_cnt;
  logic             stretch;
  logic             dout, rise, fall, busy;

  int n_cmp = 0;
  int n_bad = 0;

  slow_clk_gen #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .arst    (arst),
    .en      (en),
    .hi_cnt  (hi_cnt),
    .lo_cnt  (lo_cnt),
    .stretch (stretch),
    .dout    (dout),
    .rise    (rise),
    .fall    (fall),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the phase in progress and how many cycles of it remain,
  // counting the current one. A phase entered with count c lasts c+1 cycles.
  int   m_phase;   // 0 = idle, 1 = high, 2 = low
  int   m_left;
  logic m_rise, m_fall;

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_phase <= 0;
      m_left  <= 0;
      m_rise  <= 1'b0;
      m_fall  <= 1'b0;
    end else begin
      m_rise <= 1'b0;
      m_fall <= 1'b0;
      case (m_phase)
        0: if (en) begin
          m_phase <= 1;
          m_left  <= int'(hi_cnt) + 1;
          m_rise  <= 1'b1;
        end
        1: if (m_left > 1) m_left <= m_left - 1;
           else if (!stretch) begin
             m_phase <= 2;
             m_left  <= int'(lo_cnt) + 1;
             m_fall  <= 1'b1;
           end
        default: if (m_left > 1) m_left <= m_left - 1;
           else if (!stretch) begin
             if (en) begin
               m_phase <= 1;
               m_left  <= int'(hi_cnt) + 1;
               m_rise  <= 1'b1;
             end else begin
               m_phase <= 0;
             end
           end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!arst) begin
      check("dout", dout, (m_phase == 1) ? 1 : 0);
      check("rise", rise, m_rise);
      check("fall", fall, m_fall);
      check("busy", busy, (m_phase != 0) ? 1 : 0);
      check("rise_fall_excl", rise & fall, 0);
    end
  end

  // Run-length monitor on the observed slow clock.
  int   hi_runs[$];
  int   lo_runs[$];
  int   run_len = 0;
  logic run_lvl = 1'b0;

  always @(negedge clk) begin
    if (arst) begin
      run_len = 0;
      run_lvl = 1'b0;
    end else if (dout === run_lvl) begin
      run_len++;
    end else begin
      if (run_lvl) hi_runs.push_back(run_len);
      else         lo_runs.push_back(run_len);
      run_lvl = dout;
      run_len = 1;
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("idle_reached", busy, 0);
  endtask

  int busy_n, rise_n, fall_n, high_n;

  task automatic count_cycles(input int n);
    busy_n = 0; rise_n = 0; fall_n = 0; high_n = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      busy_n += int'(busy);
      rise_n += int'(rise);
      fall_n += int'(fall);
      high_n += int'(dout);
    end
  endtask

  initial begin
    arst = 1'b1; en = 1'b0; hi_cnt = '0; lo_cnt = '0; stretch = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_rise", rise, 0);
    check("rst_fall", fall, 0);
    check("rst_busy", busy, 0);

    // 3 high / 2 low, continuous.
    arst = 1'b0;
    hi_cnt = 4'd2; lo_cnt = 4'd1; en = 1'b1;
    hi_runs.delete(); lo_runs.delete();
    count_cycles(20);
    check("p32_busy_cycles", busy_n, 20);
    check("p32_rises", rise_n, 4);
    check("p32_falls", fall_n, 4);
    check("p32_hi_len", hi_runs[$], 3);
    check("p32_lo_len", lo_runs[$], 2);
    en = 1'b0;
    wait_idle();

    // Minimum phases: toggle every cycle.
    hi_cnt = 4'd0; lo_cnt = 4'd0; en = 1'b1;
    count_cycles(10);
    check("p11_rises", rise_n, 5);
    check("p11_falls", fall_n, 5);
    check("p11_hi_len", hi_runs[$], 1);
    check("p11_lo_len", lo_runs[$], 1);
    en = 1'b0;
    wait_idle();

    // Stretch held over high cycles 1-4 with hi_cnt=1 gives a 5-cycle high.
    hi_cnt = 4'd1; lo_cnt = 4'd2; en = 1'b1;
    @(negedge clk);
    stretch = 1'b1;
    repeat (4) @(negedge clk);
    stretch = 1'b0;
    check("stretch_still_high", dout, 1);
    @(negedge clk);
    check("stretch_fall", fall, 1);
    check("stretch_low", dout, 0);
    en = 1'b0;
    wait_idle();
    check("stretch_hi_len", hi_runs[$], 5);

    // en dropped in first high cycle: full 4+4 period, then idle.
    hi_cnt = 4'd3; lo_cnt = 4'd3; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    count_cycles(20);
    check("noruntt_busy_cycles", busy_n, 7);
    check("norunt_high_cycles", high_n, 3);
    check("norunt_extra_rise", rise_n, 0);
    check("norunt_idle", busy, 0);

    // Async reset mid-high, restart with en held.
    hi_cnt = 4'd3; lo_cnt = 4'd3; en = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_arst_high", dout, 1);
    #1 arst = 1'b1;
    #1;
    check("arst_dout", dout, 0);
    check("arst_fall", fall, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    check("restart_rise", rise, 1);
    check("restart_dout", dout, 1);
    en = 1'b0;
    wait_idle();

    // hi_cnt changed mid-high takes effect only on the next high phase.
    hi_cnt = 4'd2; lo_cnt = 4'd1; en = 1'b1;
    hi_runs.delete();
    @(negedge clk);
    hi_cnt = 4'd5;
    repeat (14) @(negedge clk);
    en = 1'b0;
    wait_idle();
    check("resample_first_hi", hi_runs[0], 3);
    check("resample_next_hi", hi_runs[1], 6);

    // Randomized run against the model, with occasional async resets.
    for (int i = 0; i < 600; i++) begin
      en      = ($urandom_range(0, 9) < 8);
      hi_cnt  = ($urandom_range(0, 7) == 0) ? 4'(15) : 4'($urandom_range(0, 4));
      lo_cnt  = ($urandom_range(0, 7) == 0) ? 4'(15) : 4'($urandom_range(0, 4));
      stretch = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
      end
      @(negedge clk);
    end
    en = 1'b0; stretch = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
